// File: rtl/shot_pool_pkg.sv
// rtl/shot_pool_pkg.sv - shared screen geometry and colour constants for the shot pool
package shot_pool_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int TICK_LINE = 480;

    localparam logic [5:0] COLOR_BLACK  = 6'b000000;
    localparam logic [5:0] COLOR_YELLOW = 6'b111100;

endpackage

// File: rtl/shot_slot.sv
// rtl/shot_slot.sv - one bullet slot: position state, launch/move/clear, pixel coverage
module shot_slot
    import shot_pool_pkg::*;
#(
    parameter int SPEED  = 4,
    parameter int SHOT_W = 4,
    parameter int SHOT_H = 8,
    parameter int GUN_Y  = 440
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic       hit,
    input  logic [9:0] launch_x,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       active,
    output logic       active_next,
    output logic       covers
);

    localparam logic [9:0] LAUNCH_Y = 10'(GUN_Y - SHOT_H);
    localparam logic [9:0] STEP     = 10'(SPEED);

    logic       active_q, active_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [10:0] x_end, y_end;

    // A hit wins over everything; launch is only offered to an idle slot, so it never moves on its launch tick.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        if (hit && active_q) begin
            active_d = 1'b0;
        end else if (launch) begin
            active_d = 1'b1;
            x_d      = launch_x;
            y_d      = LAUNCH_Y;
        end else if (frame_tick && active_q) begin
            if (y_q >= STEP) begin
                y_d = y_q - STEP;
            end else begin
                active_d = 1'b0;
            end
        end
    end

    // 11-bit compare so a bullet near column 639 does not wrap onto column 0.
    always_comb begin
        x_end  = {1'b0, x_q} + 11'(SHOT_W);
        y_end  = {1'b0, y_q} + 11'(SHOT_H);
        covers = active_q
              && ({1'b0, hcount} >= {1'b0, x_q}) && ({1'b0, hcount} < x_end)
              && ({1'b0, vcount} >= {1'b0, y_q}) && ({1'b0, vcount} < y_end);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active      = active_q;
    assign active_next = active_d;

endmodule

// File: rtl/shot_pool.sv
// rtl/shot_pool.sv - bullet pool: fire synchroniser, cooldown, launch arbitration, pixel output
module shot_pool
    import shot_pool_pkg::*;
#(
    parameter int         N_SHOTS    = 4,
    parameter int         SPEED      = 4,
    parameter int         COOLDOWN   = 8,
    parameter int         SHOT_W     = 4,
    parameter int         SHOT_H     = 8,
    parameter int         GUN_Y      = 440,
    parameter logic [5:0] SHOT_COLOR = COLOR_YELLOW
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic               fire,
    input  logic [9:0]         pos_x,
    input  logic [N_SHOTS-1:0] hit_mask,
    output logic               shot_draw,
    output logic [5:0]         shot_data,
    output logic [3:0]         shots_active,
    output logic               fire_accepted
);

    logic        fire_s1_q, fire_s1_d;
    logic        fire_s2_q, fire_s2_d;
    logic        fire_prev_q, fire_prev_d;
    logic [1:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic [15:0] cooldown_q, cooldown_d;
    logic        draw_q, draw_d;
    logic [5:0]  data_q, data_d;
    logic [3:0]  count_q, count_d;
    logic        accepted_q, accepted_d;

    logic               frame_tick;
    logic               fire_req;
    logic               found;
    logic               launch_go;
    logic [N_SHOTS-1:0] launch_sel;
    logic [N_SHOTS-1:0] launch_vec;
    logic [N_SHOTS-1:0] slot_active;
    logic [N_SHOTS-1:0] slot_next;
    logic [N_SHOTS-1:0] slot_cover;

    always_comb begin
        fire_s1_d   = fire;
        fire_s2_d   = fire_s1_q;
        fire_prev_d = fire_s2_q;
        // Arm only once the synchroniser has refilled and shows a released button, so a press held through reset is ignored.
        settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d     = armed_q | ((settle_q == 2'd2) && !fire_s2_q);
        fire_req    = armed_q && fire_s2_q && !fire_prev_q;

        frame_tick  = (hcount == 10'd0) && (vcount == 10'(TICK_LINE));

        launch_sel = '0;
        found      = 1'b0;
        for (int i = 0; i < N_SHOTS; i++) begin
            if (!found && !slot_active[i]) begin
                launch_sel[i] = 1'b1;
                found         = 1'b1;
            end
        end
        launch_go  = fire_req && (cooldown_q == 16'd0) && found;
        launch_vec = launch_go ? launch_sel : '0;
        accepted_d = launch_go;

        if (launch_go) begin
            cooldown_d = 16'(COOLDOWN);
        end else if (frame_tick && (cooldown_q != 16'd0)) begin
            cooldown_d = cooldown_q - 16'd1;
        end else begin
            cooldown_d = cooldown_q;
        end

        draw_d = |slot_cover;
        data_d = draw_d ? SHOT_COLOR : COLOR_BLACK;

        count_d = '0;
        for (int i = 0; i < N_SHOTS; i++) begin
            count_d = count_d + {3'b000, slot_next[i]};
        end
    end

    for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
        shot_slot #(
            .SPEED  (SPEED),
            .SHOT_W (SHOT_W),
            .SHOT_H (SHOT_H),
            .GUN_Y  (GUN_Y)
        ) u_slot (
            .vga_clk     (vga_clk),
            .reset       (reset),
            .frame_tick  (frame_tick),
            .launch      (launch_vec[g]),
            .hit         (hit_mask[g]),
            .launch_x    (pos_x),
            .hcount      (hcount),
            .vcount      (vcount),
            .active      (slot_active[g]),
            .active_next (slot_next[g]),
            .covers      (slot_cover[g])
        );
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_prev_q <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            cooldown_q  <= '0;
            draw_q      <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            accepted_q  <= 1'b0;
        end else begin
            fire_s1_q   <= fire_s1_d;
            fire_s2_q   <= fire_s2_d;
            fire_prev_q <= fire_prev_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            cooldown_q  <= cooldown_d;
            draw_q      <= draw_d;
            data_q      <= data_d;
            count_q     <= count_d;
            accepted_q  <= accepted_d;
        end
    end

    assign shot_draw     = draw_q;
    assign shot_data     = data_q;
    assign shots_active  = count_q;
    assign fire_accepted = accepted_q;

endmodule

// File: tb/tb_shot_pool.sv
// tb/tb_shot_pool.sv - randomized scoreboard bench for shot_pool against a frame-level bullet model
module tb_shot_pool;

    localparam int         N   = 4;
    localparam int         SPD = 4;
    localparam int         CD  = 8;
    localparam int         SW  = 4;
    localparam int         SH  = 8;
    localparam int         GY  = 440;
    localparam logic [5:0] COL = 6'b111100;

    logic         vga_clk = 1'b0;
    logic         reset;
    logic [9:0]   hcount;
    logic [9:0]   vcount;
    logic         fire;
    logic [9:0]   pos_x;
    logic [N-1:0] hit_mask;
    logic         shot_draw;
    logic [5:0]   shot_data;
    logic [3:0]   shots_active;
    logic         fire_accepted;

    always #5 vga_clk = ~vga_clk;

    shot_pool #(
        .N_SHOTS    (N),
        .SPEED      (SPD),
        .COOLDOWN   (CD),
        .SHOT_W     (SW),
        .SHOT_H     (SH),
        .GUN_Y      (GY),
        .SHOT_COLOR (COL)
    ) dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .fire          (fire),
        .pos_x         (pos_x),
        .hit_mask      (hit_mask),
        .shot_draw     (shot_draw),
        .shot_data     (shot_data),
        .shots_active  (shots_active),
        .fire_accepted (fire_accepted)
    );

    typedef struct packed {
        logic       acc;
        logic [3:0] cnt;
        logic       draw;
        logic [5:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   m_act[N];
    int   m_x[N];
    int   m_y[N];
    int   m_cd;
    bit   m_prev;
    int   m_pend[$];
    int   cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a press is a low-then-high sample of fire after reset, launching two edges after the high sample.
    task automatic model_edge();
        exp_t e;
        bit   req;
        bit   tick;
        int   slot;
        int   cnt;
        cyc++;
        e = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd   = 0;
            m_prev = 1;
            m_pend.delete();
            sb.push_back(e);
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && int'(hcount) >= m_x[i] && int'(hcount) < m_x[i] + SW
                && int'(vcount) >= m_y[i] && int'(vcount) < m_y[i] + SH)
                e.draw = 1'b1;
        end
        e.data = e.draw ? COL : 6'd0;
        req = 0;
        if (m_pend.size() > 0 && m_pend[0] == cyc) begin
            req = 1;
            void'(m_pend.pop_front());
        end
        if (fire && !m_prev) m_pend.push_back(cyc + 2);
        m_prev = fire;
        tick = (hcount == 10'd0) && (vcount == 10'd480);
        slot = -1;
        if (req && m_cd == 0) begin
            for (int i = 0; i < N; i++)
                if (slot < 0 && !m_act[i]) slot = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && hit_mask[i]) begin
                m_act[i] = 0;
            end else if (i == slot) begin
                m_act[i] = 1; m_x[i] = int'(pos_x); m_y[i] = GY - SH;
            end else if (m_act[i] && tick) begin
                if (m_y[i] >= SPD) m_y[i] = m_y[i] - SPD;
                else m_act[i] = 0;
            end
        end
        if (slot >= 0) m_cd = CD;
        else if (tick && m_cd > 0) m_cd = m_cd - 1;
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(m_act[i]);
        e.acc = (slot >= 0);
        e.cnt = 4'(cnt);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge vga_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fire_accepted", int'(fire_accepted), int'(e.acc));
                chk("shots_active", int'(shots_active), int'(e.cnt));
                chk("shot_draw", int'(shot_draw), int'(e.draw));
                chk("shot_data", int'(shot_data), int'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge vga_clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        hcount = 10'd1; vcount = 10'd0;
        repeat (n) step();
    endtask

    task automatic tick();
        hcount = 10'd0; vcount = 10'd480;
        step();
        hcount = 10'd1; vcount = 10'd0;
    endtask

    task automatic press();
        fire = 1'b1;
        repeat (3) step();
        fire = 1'b0;
        repeat (3) step();
    endtask

    task automatic probe(input int h, input int v);
        hcount = 10'(h); vcount = 10'(v);
        step();
        hcount = 10'd1; vcount = 10'd0;
    endtask

    task automatic probe_near();
        int i;
        int h;
        int v;
        i = int'($urandom_range(0, N - 1));
        h = m_x[i] + int'($urandom_range(0, SW + 1)) - 1;
        v = m_y[i] + int'($urandom_range(0, SH + 1)) - 1;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        probe(h, v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        idle(4);
    endtask

    initial begin : stimulus
        reset = 1'b1; fire = 1'b1; pos_x = 10'd0; hit_mask = '0;
        hcount = 10'd1; vcount = 10'd0;
        // fire held through reset and after release must not launch
        repeat (4) step();
        reset = 1'b0;
        repeat (6) step();
        fire = 1'b0;
        idle(4);

        pos_x = 10'd100;
        press();
        probe(101, 435); probe(99, 435); probe(104, 435);
        probe(103, 439); probe(103, 440); probe(100, 432); probe(100, 431);

        for (int f = 0; f < 10; f++) begin
            press();
            tick();
        end

        for (int k = 0; k < 4; k++) begin
            repeat (8) tick();
            pos_x = 10'(40 * k + 20);
            press();
        end
        repeat (8) tick();
        press();
        probe_near(); probe_near();

        reset = 1'b1; step(); reset = 1'b0;
        idle(3);

        pos_x = 10'd300;
        press();
        for (int t = 0; t < 115; t++) begin
            tick();
            probe_near();
        end

        do_reset();
        pos_x = 10'd638;
        press();
        for (int h = 636; h <= 641; h++) probe(h, 435);
        probe(0, 435); probe(1, 435);

        do_reset();
        pos_x = 10'd50;  press(); repeat (8) tick();
        pos_x = 10'd150; press(); repeat (8) tick();
        pos_x = 10'd250;
        fire = 1'b1;
        step(); step();
        hit_mask = 4'b0001;
        step();
        hit_mask = '0;
        fire = 1'b0;
        idle(3);
        probe(51, 370); probe(151, 370); probe(251, 435);

        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) fire = ~fire;
            hit_mask = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
            pos_x    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(630, 639))
                                                   : 10'($urandom_range(0, 639));
            if ($urandom_range(0, 7) == 0) begin
                tick();
            end else if ($urandom_range(0, 1) == 0) begin
                probe_near();
            end else begin
                probe(int'($urandom_range(0, 700)), int'($urandom_range(0, 524)));
            end
        end
        reset = 1'b0; fire = 1'b0; hit_mask = '0;
        idle(4);
        @(negedge vga_clk);
        @(negedge vga_clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
